// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-path constants, FSM states and the fetch queue record
package cpu_pkg;
  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] RESET_PC = '0;
  localparam int INST_W = 32;
  localparam int ADDR_W = 6;
  localparam int ROM_LAT = 1;
  localparam int DEPTH = 2;
  typedef enum logic {IDLE, FETCH} fetch_state_t;
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_ctrl_if.sv
// fetch_ctrl_if: redirect, instruction ROM and decode handshake signals of the fetch stage
interface fetch_ctrl_if
  import cpu_pkg::*;
#(
  parameter int PC_W   = cpu_pkg::PC_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W
);
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [INST_W-1:0] rom_data;
  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] out_inst;
  logic [PC_W-1:0]   out_pc;
  logic [PC_W-1:0]   out_pc4;
  logic              align_err;
  modport master (
    input  redirect_valid, redirect_pc, rom_data, out_ready,
    output rom_en, rom_addr, out_valid, out_inst, out_pc, out_pc4, align_err
  );
  modport slave (
    output redirect_valid, redirect_pc, rom_data, out_ready,
    input  rom_en, rom_addr, out_valid, out_inst, out_pc, out_pc4, align_err
  );
endinterface

// File: rtl/fetch_skid_q.sv
// fetch_skid_q: 2-entry FIFO of fetched words; head always sits in mem[0]
module fetch_skid_q
  import cpu_pkg::*;
#(
  parameter int DEPTH = cpu_pkg::DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);
  fetch_entry_t mem [2];
  logic [1:0] wp;
  assign wp = count - {1'b0, pop};
  assign head = mem[0];
  // shift on pop, write the incoming word into the first free slot after the shift
  always_ff @(posedge clk)
    if (!rst) begin
      count <= '0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      count <= flush ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
      mem[0] <= (push && wp == 2'd0) ? din : pop ? mem[1] : mem[0];
      mem[1] <= (push && wp == 2'd1) ? din : mem[1];
    end
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && !pop && count == 2'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst) !(pop && count == 2'd0));
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: issues ROM reads, tags returning words with their PC and queues them for decode
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int              PC_W     = cpu_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter int              ADDR_W   = cpu_pkg::ADDR_W,
  parameter int              DEPTH    = cpu_pkg::DEPTH
) (
  input logic          clk,
  input logic          rst,
  fetch_ctrl_if.master bus
);
  fetch_state_t state, state_n;
  logic [PC_W-1:0] fetch_pc, fetch_pc_n, inflight_pc, inflight_pc_n;
  logic inflight, inflight_n, align_q, align_n;
  logic pop, push, issue, flush;
  logic [1:0] count;
  logic [2:0] occ;
  fetch_entry_t head, din;
  fetch_skid_q #(.DEPTH(DEPTH)) u_q (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (din),
    .head  (head),
    .count (count)
  );
  assign bus.out_valid = count != 2'd0;
  assign pop = bus.out_valid & bus.out_ready;
  assign din = '{inst: bus.rom_data, pc: inflight_pc};
  assign bus.rom_en = issue;
  assign bus.rom_addr = fetch_pc[ADDR_W+1:2];
  assign bus.align_err = align_q;
  assign bus.out_inst = bus.out_valid ? head.inst : '0;
  assign bus.out_pc = bus.out_valid ? head.pc : '0;
  assign bus.out_pc4 = bus.out_valid ? head.pc + PC_W'(4) : '0;
  // state, PC and in-flight read registers
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
      inflight_pc <= '0;
      align_q <= 1'b0;
    end else begin
      state <= state_n;
      fetch_pc <= fetch_pc_n;
      inflight <= inflight_n;
      inflight_pc <= inflight_pc_n;
      align_q <= align_n;
    end
  // issue only while queued + in-flight words, net of this cycle's pop, leave a free slot
  always_comb begin
    state_n = FETCH;
    occ = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    issue = state == FETCH && !bus.redirect_valid && occ < 3'd2;
    push = state == FETCH && inflight && !bus.redirect_valid;
    flush = state == FETCH && bus.redirect_valid;
    fetch_pc_n = bus.redirect_valid ? {bus.redirect_pc[PC_W-1:2], 2'b00} : issue ? fetch_pc + PC_W'(4) : fetch_pc;
    inflight_n = issue;
    inflight_pc_n = issue ? fetch_pc : inflight_pc;
    align_n = bus.redirect_valid && bus.redirect_pc[1:0] != 2'b00;
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and randomized checks of fetch_ctrl against a queue-based model
module tb_fetch_ctrl;
  import cpu_pkg::*;
  logic clk, rst;
  logic [31:0] rom [64];
  int tests, fails;
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;
  ent_t mq[$];
  bit m_idle, m_inf, m_align;
  logic [31:0] m_pc, m_ipc;
  fetch_ctrl_if #(.PC_W(32), .ADDR_W(6)) ifc ();
  fetch_ctrl #(.PC_W(32), .RESET_PC(32'h0), .ADDR_W(6), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.master)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always_ff @(posedge clk) if (ifc.rom_en) ifc.rom_data <= rom[ifc.rom_addr];
  function automatic bit m_pop();
    return mq.size() != 0 && ifc.out_ready;
  endfunction
  function automatic bit m_en();
    return !m_idle && !ifc.redirect_valid && (int'(mq.size()) + int'(m_inf) - int'(m_pop())) < 2;
  endfunction
  task automatic step();
    bit p;
    int occ;
    @(posedge clk);
    p = m_pop();
    if (!rst) begin
      m_idle = 1; m_pc = 32'h0; mq.delete(); m_inf = 0; m_align = 0;
    end else if (m_idle || ifc.redirect_valid) begin
      if (ifc.redirect_valid) m_pc = {ifc.redirect_pc[31:2], 2'b00};
      m_align = ifc.redirect_valid && ifc.redirect_pc[1:0] != 2'b00;
      if (!m_idle) begin mq.delete(); m_inf = 0; end
      m_idle = 0;
    end else begin
      occ = int'(mq.size()) + int'(m_inf) - int'(p);
      if (p) void'(mq.pop_front());
      if (m_inf) mq.push_back('{rom[m_ipc[7:2]], m_ipc});
      m_inf = occ < 2;
      if (occ < 2) begin m_ipc = m_pc; m_pc = m_pc + 32'd4; end
      m_align = 0;
    end
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 0; ifc.redirect_valid = 0;
    step(); step();
    rst = 1;
  endtask
  task automatic test_reset();
    rst = 0; ifc.out_ready = 1; ifc.redirect_valid = 1; ifc.redirect_pc = 32'h43;
    step(); step(); #1;
    tests++; if (ifc.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", ifc.out_valid); end
    tests++; if (ifc.rom_en !== 1'b0) begin fails++; $display("FAIL reset_rom_en got %b exp 0", ifc.rom_en); end
    tests++; if (ifc.align_err !== 1'b0) begin fails++; $display("FAIL reset_align got %b exp 0", ifc.align_err); end
    tests++; if (ifc.out_inst !== 32'h0) begin fails++; $display("FAIL reset_inst got %h exp 0", ifc.out_inst); end
    tests++; if (ifc.out_pc !== 32'h0) begin fails++; $display("FAIL reset_pc got %h exp 0", ifc.out_pc); end
    tests++; if (ifc.out_pc4 !== 32'h0) begin fails++; $display("FAIL reset_pc4 got %h exp 0", ifc.out_pc4); end
    ifc.redirect_valid = 0; rst = 1; #1;
    tests++; if (ifc.rom_en !== 1'b0) begin fails++; $display("FAIL idle_rom_en got %b exp 0", ifc.rom_en); end
    step(); #1;
    tests++; if (ifc.rom_en !== 1'b1 || ifc.rom_addr !== 6'd0) begin fails++; $display("FAIL first_fetch en %b addr %0d exp 1/0", ifc.rom_en, ifc.rom_addr); end
  endtask
  task automatic test_stream();
    ifc.out_ready = 1; do_reset(); #1;
    tests++; if (ifc.rom_en !== 1'b0) begin fails++; $display("FAIL stream_idle got %b exp 0", ifc.rom_en); end
    step(); #1;
    tests++; if (ifc.rom_en !== 1'b1 || ifc.rom_addr !== 6'd0) begin fails++; $display("FAIL stream_c2 en %b addr %0d exp 1/0", ifc.rom_en, ifc.rom_addr); end
    step(); #1;
    tests++; if (ifc.rom_en !== 1'b1 || ifc.rom_addr !== 6'd1 || ifc.out_valid !== 1'b0) begin fails++; $display("FAIL stream_c3 en %b addr %0d v %b exp 1/1/0", ifc.rom_en, ifc.rom_addr, ifc.out_valid); end
    step(); #1;
    tests++; if (ifc.out_valid !== 1'b1 || ifc.out_inst !== 32'h1000 || ifc.out_pc !== 32'h0 || ifc.out_pc4 !== 32'h4) begin fails++; $display("FAIL stream_first v %b inst %h pc %h pc4 %h exp 1/1000/0/4", ifc.out_valid, ifc.out_inst, ifc.out_pc, ifc.out_pc4); end
    for (int k = 1; k <= 6; k++) begin
      step(); #1;
      tests++; if (ifc.out_valid !== 1'b1 || ifc.out_pc !== 32'(4 * k) || ifc.out_inst !== 32'(32'h1000 + k)) begin fails++; $display("FAIL stream_word%0d v %b pc %h inst %h exp pc %h", k, ifc.out_valid, ifc.out_pc, ifc.out_inst, 4 * k); end
    end
  endtask
  task automatic test_backpressure();
    bit got;
    logic [31:0] pcs[$];
    ifc.out_ready = 0; do_reset(); got = 0;
    for (int i = 0; i < 10; i++) begin #1; if (ifc.out_valid) begin got = 1; break; end step(); end
    tests++; if (!got) begin fails++; $display("FAIL bp_first_valid got 0 exp 1 within 10 cycles"); end
    for (int i = 0; i < 5; i++) begin
      tests++; if (ifc.out_valid !== 1'b1 || ifc.out_pc !== 32'h0 || ifc.out_inst !== 32'h1000 || ifc.rom_en !== 1'b0) begin fails++; $display("FAIL bp_hold%0d v %b pc %h inst %h en %b exp 1/0/1000/0", i, ifc.out_valid, ifc.out_pc, ifc.out_inst, ifc.rom_en); end
      step(); #1;
    end
    ifc.out_ready = 1;
    for (int i = 0; i < 10 && pcs.size() < 3; i++) begin #1; if (ifc.out_valid) pcs.push_back(ifc.out_pc); step(); end
    tests++; if (pcs.size() != 3 || pcs[0] !== 32'h0 || pcs[1] !== 32'h4 || pcs[2] !== 32'h8) begin fails++; $display("FAIL bp_release got %0d words %p exp 0,4,8", pcs.size(), pcs); end
  endtask
  task automatic test_redirect();
    bit got;
    ifc.out_ready = 0; do_reset(); got = 0;
    for (int i = 0; i < 10; i++) begin #1; if (ifc.out_valid) begin got = 1; break; end step(); end
    tests++; if (!got) begin fails++; $display("FAIL rd_fill got 0 exp out_valid within 10 cycles"); end
    ifc.out_ready = 1; ifc.redirect_valid = 1; ifc.redirect_pc = 32'h40; #1;
    tests++; if (ifc.rom_en !== 1'b0 || ifc.out_pc !== 32'h0) begin fails++; $display("FAIL rd_cycle en %b pc %h exp 0/0", ifc.rom_en, ifc.out_pc); end
    step(); ifc.redirect_valid = 0; #1;
    tests++; if (ifc.out_valid !== 1'b0 || ifc.rom_en !== 1'b1 || ifc.rom_addr !== 6'h10) begin fails++; $display("FAIL rd_next v %b en %b addr %h exp 0/1/10", ifc.out_valid, ifc.rom_en, ifc.rom_addr); end
    step(); #1;
    tests++; if (ifc.out_valid !== 1'b0) begin fails++; $display("FAIL rd_drop got %b exp 0", ifc.out_valid); end
    step(); #1;
    tests++; if (ifc.out_valid !== 1'b1 || ifc.out_pc !== 32'h40 || ifc.out_inst !== 32'h1010) begin fails++; $display("FAIL rd_target v %b pc %h inst %h exp 1/40/1010", ifc.out_valid, ifc.out_pc, ifc.out_inst); end
  endtask
  task automatic test_align();
    ifc.out_ready = 1; ifc.redirect_valid = 1; ifc.redirect_pc = 32'h43; #1;
    tests++; if (ifc.align_err !== 1'b0) begin fails++; $display("FAIL al_early got %b exp 0", ifc.align_err); end
    step(); ifc.redirect_valid = 0; #1;
    tests++; if (ifc.align_err !== 1'b1 || ifc.rom_en !== 1'b1 || ifc.rom_addr !== 6'h10) begin fails++; $display("FAIL al_pulse a %b en %b addr %h exp 1/1/10", ifc.align_err, ifc.rom_en, ifc.rom_addr); end
    step(); #1;
    tests++; if (ifc.align_err !== 1'b0) begin fails++; $display("FAIL al_clear got %b exp 0", ifc.align_err); end
    step(); #1;
    tests++; if (ifc.out_pc !== 32'h40) begin fails++; $display("FAIL al_resume got %h exp 40", ifc.out_pc); end
  endtask
  task automatic test_wrap();
    ifc.out_ready = 1; ifc.redirect_valid = 1; ifc.redirect_pc = 32'hFC;
    step(); ifc.redirect_valid = 0; #1;
    tests++; if (ifc.rom_addr !== 6'd63) begin fails++; $display("FAIL wr_addr63 got %0d exp 63", ifc.rom_addr); end
    step(); #1;
    tests++; if (ifc.rom_addr !== 6'd0) begin fails++; $display("FAIL wr_addr0 got %0d exp 0", ifc.rom_addr); end
    step(); #1;
    tests++; if (ifc.out_pc !== 32'hFC || ifc.out_inst !== 32'h103F) begin fails++; $display("FAIL wr_pcfc pc %h inst %h exp fc/103f", ifc.out_pc, ifc.out_inst); end
    step(); #1;
    tests++; if (ifc.out_pc !== 32'h100 || ifc.out_inst !== 32'h1000) begin fails++; $display("FAIL wr_pc100 pc %h inst %h exp 100/1000", ifc.out_pc, ifc.out_inst); end
    ifc.redirect_valid = 1; ifc.redirect_pc = 32'hFFFF_FFFC;
    step(); ifc.redirect_valid = 0; step(); step(); #1;
    tests++; if (ifc.out_pc !== 32'hFFFF_FFFC || ifc.out_pc4 !== 32'h0) begin fails++; $display("FAIL wr_top pc %h pc4 %h exp fffffffc/0", ifc.out_pc, ifc.out_pc4); end
    step(); #1;
    tests++; if (ifc.out_pc !== 32'h0) begin fails++; $display("FAIL wr_pcwrap got %h exp 0", ifc.out_pc); end
  endtask
  task automatic test_reset_mid();
    bit got;
    ifc.out_ready = 0;
    step(); step(); step(); #1;
    tests++; if (ifc.out_valid !== 1'b1 || ifc.rom_en !== 1'b0) begin fails++; $display("FAIL rm_full v %b en %b exp 1/0", ifc.out_valid, ifc.rom_en); end
    rst = 0; step(); #1;
    tests++; if (ifc.out_valid !== 1'b0 || ifc.rom_en !== 1'b0) begin fails++; $display("FAIL rm_cleared v %b en %b exp 0/0", ifc.out_valid, ifc.rom_en); end
    rst = 1; ifc.out_ready = 1; got = 0;
    for (int i = 0; i < 10; i++) begin #1; if (ifc.out_valid) begin got = 1; break; end step(); end
    tests++; if (!got || ifc.out_pc !== 32'h0 || ifc.out_inst !== 32'h1000) begin fails++; $display("FAIL rm_restart v %b pc %h inst %h exp 1/0/1000", got, ifc.out_pc, ifc.out_inst); end
  endtask
  task automatic test_random();
    bit ev, ee;
    rst = 0; ifc.redirect_valid = 0;
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    step(); step(); rst = 1;
    for (int c = 0; c < 600; c++) begin
      ifc.out_ready = $urandom_range(0, 9) < 7;
      ifc.redirect_valid = $urandom_range(0, 15) == 0;
      ifc.redirect_pc = $urandom_range(0, 3) == 0 ? $urandom : ($urandom & 32'h1FF);
      rst = $urandom_range(0, 79) != 0;
      #1;
      ev = mq.size() != 0; ee = m_en();
      tests++; if (ifc.out_valid !== ev) begin fails++; $display("FAIL rnd_valid c%0d got %b exp %b", c, ifc.out_valid, ev); end
      if (ev) begin
        tests++; if (ifc.out_inst !== mq[0].inst || ifc.out_pc !== mq[0].pc || ifc.out_pc4 !== mq[0].pc + 32'd4) begin fails++; $display("FAIL rnd_head c%0d inst %h pc %h pc4 %h exp %h/%h", c, ifc.out_inst, ifc.out_pc, ifc.out_pc4, mq[0].inst, mq[0].pc); end
      end
      tests++; if (ifc.rom_en !== ee) begin fails++; $display("FAIL rnd_en c%0d got %b exp %b", c, ifc.rom_en, ee); end
      if (ee) begin
        tests++; if (ifc.rom_addr !== m_pc[7:2]) begin fails++; $display("FAIL rnd_addr c%0d got %h exp %h", c, ifc.rom_addr, m_pc[7:2]); end
      end
      tests++; if (ifc.align_err !== m_align) begin fails++; $display("FAIL rnd_align c%0d got %b exp %b", c, ifc.align_err, m_align); end
      step();
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    tests = 0; fails = 0;
    rst = 0; ifc.redirect_valid = 0; ifc.redirect_pc = '0; ifc.out_ready = 0;
    for (int i = 0; i < 64; i++) rom[i] = 32'h1000 + 32'(i);
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_align();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
